// File: rtl/interface_keypad.sv
// interface_keypad: memory-mapped 4x4 matrix keypad scanner with debounce and a read-to-clear key register.
// Latency: the 2-flop row sync, then valid rises 1 clk after the DEBOUNCE_SCANS-th matching sweep; rdata is combinational.
// Backpressure: none. A new key latched before the previous one was read sets overrun.
//
// Ports: clk/rst (async, active-high); addr/re/rdata form the CPU load path.
//        row_n in (active-low, asynchronous); col_n out (active-low strobes); irq out.
// Parameters: SCAN_DIV (clk cycles per column), DEBOUNCE_SCANS (sweeps needed to accept), BASE_ADDR.
// Register map: BASE_ADDR = status {overrun, valid}; BASE_ADDR+4 = data {valid, code[3:0]}.
// Option: define KEYPAD_IRQ_EN to drive irq from valid. Without it, irq is tied low.
module interface_keypad #(
    parameter int unsigned SCAN_DIV       = 12000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter logic [31:0] BASE_ADDR      = 32'hFFFF_F010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic        irq
);
    localparam int unsigned   CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned   DW       = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_N    = DW'(DEBOUNCE_SCANS);
    localparam logic [DW-1:0] CNT_ONE  = DW'(1);
    localparam bit            ONE_SCAN = (DEBOUNCE_SCANS <= 1);

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

    logic [CW-1:0] r_div;
    logic [1:0]    r_col;
    logic [3:0]    r_row_s1, r_row_s2;
    logic [15:0]   r_key_map;
    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]    r_cand, w_cand_nxt;
    logic [3:0]    r_code;
    logic          r_valid, r_overrun;

    logic          w_sample, w_sweep_end, w_latch, w_data_rd;
    logic [15:0]   w_map_now;
    logic [4:0]    w_ones;
    logic [3:0]    w_code;
    logic          w_single, w_empty;

    assign w_sample    = (r_div == DIV_LAST);
    assign w_sweep_end = w_sample && (r_col == 2'd3);
    assign w_data_rd   = re && (addr == BASE_ADDR + 32'd4);
    assign col_n       = ~(4'b0001 << r_col);

    // The sweep is judged on the same edge that samples column 3, so that
    // column is taken from the synchronizer rather than the stored map.
    always_comb begin
        w_map_now        = r_key_map;
        w_map_now[15:12] = ~r_row_s2;
        w_ones           = '0;
        w_code           = '0;
        for (int i = 0; i < 16; i++) begin
            if (w_map_now[i]) begin
                w_ones = w_ones + 5'd1;
                w_code = 4'(i);
            end
        end
    end

    assign w_single = (w_ones == 5'd1);
    assign w_empty  = (w_ones == 5'd0);

    // Scan timing and row sampling run freely, independent of the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div     <= '0;
            r_col     <= '0;
            r_row_s1  <= 4'hF;
            r_row_s2  <= 4'hF;
            r_key_map <= '0;
        end else begin
            r_row_s1 <= row_n;
            r_row_s2 <= r_row_s1;
            if (w_sample) begin
                r_div                   <= '0;
                r_col                   <= r_col + 2'd1;
                r_key_map[r_col*4 +: 4] <= ~r_row_s2;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    // Debounce FSM. It moves only at sweep end and latches at most once per press.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_latch     = 1'b0;
        if (w_sweep_end) begin
            case (r_state)
                S_IDLE: begin
                    if (w_single) begin
                        w_cand_nxt = w_code;
                        w_cnt_nxt  = CNT_ONE;
                        if (ONE_SCAN) begin
                            w_latch     = 1'b1;
                            w_state_nxt = S_HELD;
                        end else begin
                            w_state_nxt = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (w_single && (w_code == r_cand)) begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                        if (w_cnt_nxt == DEB_N) begin
                            w_latch     = 1'b1;
                            w_state_nxt = S_HELD;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (w_empty) begin
                        w_cnt_nxt   = CNT_ONE;
                        w_state_nxt = ONE_SCAN ? S_IDLE : S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (w_empty) begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                        if (w_cnt_nxt == DEB_N) w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_HELD;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_cand    <= '0;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cand  <= w_cand_nxt;
            // A latch wins over a same-cycle data read. The read consumed
            // the old key, so overrun is not flagged.
            if (w_latch) begin
                r_code    <= w_cand_nxt;
                r_valid   <= 1'b1;
                r_overrun <= r_valid && !w_data_rd;
            end else if (w_data_rd) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (addr == BASE_ADDR)
            rdata = {30'b0, r_overrun, r_valid};
        else if (addr == BASE_ADDR + 32'd4)
            rdata = {27'b0, r_valid, r_code};
    end

`ifdef KEYPAD_IRQ_EN
    assign irq = r_valid;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: doc/interface_keypad.md
# interface_keypad

Memory-mapped 4x4 matrix keypad input peripheral; the CPU-readable counterpart of the seven-segment output interface. Drives active-low column strobes, samples active-low row lines, debounces a single key press and holds its 4-bit code in a read-to-clear register on the CPU load path. It sits beside the display interface on the single-cycle core's data-memory bus and decodes its own address.

## Interface
- SCAN_DIV, 12000: clk cycles each column stays strobed.
- DEBOUNCE_SCANS, 4: consecutive identical full sweeps required to accept a press or a release.
- BASE_ADDR, 32'hFFFF_F010: status register address; data register is at BASE_ADDR+4.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- addr  in  32  CPU byte address.
- re  in  1  CPU read strobe, qualified by addr.
- rdata  out  32  combinational read data.
- row_n  in  4  keypad rows, active-low, asynchronous to clk.
- col_n  out  4  column strobes, active-low, one-hot-zero.
- irq  out  1  key-available interrupt (see Configuration).

## Operation
- Scan: dwell counter 0..SCAN_DIV-1; col_n = ~(4'b0001 << col_idx); col_idx advances 0->1->2->3->0 when the counter wraps.
- row_n passes through a 2-flop synchronizer; the synchronized value is sampled into key_map[col_idx*4 +: 4] (inverted, 1 = pressed) on the cycle the counter equals SCAN_DIV-1.
- Sweep end: the wrap from col 3 to col 0. A sweep is "single" if exactly one key_map bit is set (candidate code = col*4 + row), "empty" if none, "multi" otherwise.
- FSM, evaluated only at sweep end:
  - IDLE: single -> DEBOUNCE with cand = code, cnt = 1; otherwise stay.
  - DEBOUNCE: single with same code -> cnt+1; at cnt == DEBOUNCE_SCANS latch code, go HELD. Different code, empty or multi -> IDLE.
  - HELD: empty -> RELEASE with cnt = 1; single/multi -> stay, with no new latch (no auto-repeat).
  - RELEASE: empty -> cnt+1, to IDLE at cnt == DEBOUNCE_SCANS; any key -> HELD.
- Latch: code <= cand, valid <= 1; overrun <= 1 if valid was already 1.
- Read map: addr == BASE_ADDR -> {30'b0, overrun, valid}; addr == BASE_ADDR+4 -> {27'b0, valid, code}; other addresses -> 0. Reads are side-effect free except a data read with re=1, which clears valid and overrun on the next clk edge.
- Simultaneous data read and latch in the same cycle: new code stored, valid = 1, overrun = 0. rdata in that cycle shows the old value.
- Status reads never clear anything.

## Timing
- Reset values: col_n = 4'b1110, rdata combinationally reflects cleared registers (0), irq = 0, valid = overrun = 0, code = 0, FSM = IDLE, counter = 0, col_idx = 0, key_map = 0.
- Sweep period 4*SCAN_DIV cycles; the first sample occurs SCAN_DIV cycles after reset release.
- Press acceptance: valid rises 1 cycle after the end of the DEBOUNCE_SCANS-th qualifying sweep.
- Sync latency is 2 cycles; SCAN_DIV >= 4 is required so settled rows are sampled.
- rst asserted mid-scan or mid-debounce aborts immediately to the reset state; a pending code is lost.
- Counter and column wrap are free-running and are unaffected by bus activity.

## Configuration
- KEYPAD_IRQ_EN defined: irq = valid (level, high until a data read clears it).
- Not defined: irq is tied to 0 and no extra logic is built. Register behaviour is identical in both cases.

## Test plan
Bench runs with SCAN_DIV=8 and DEBOUNCE_SCANS=2.
- Reset, then 100 cycles of row_n = 4'hF -> col_n rotates 1110, 1101, 1011, 0111 every 8 cycles; status read = 0; irq = 0.
- Hold key col 2 / row 1 (row_n[1] low while col_n[2] low) for 3 sweeps -> valid = 1 after the 2nd sweep; data read = 32'h19 (valid=1, code 9); next status read = 0.
- Bounce: key present 1 sweep, absent 1 sweep, repeated -> valid never set.
- Press key 3, release with no read, then press key 5 -> status = 32'h3, data = 32'h15; after the data read, status = 0.
- Two keys held at once from IDLE -> no latch. After one key is latched and in HELD, adding a second key -> no new latch, valid unchanged.
- Assert rst during DEBOUNCE -> col_n = 1110 and status = 0 in the same cycle. With KEYPAD_IRQ_EN, irq follows valid in the press scenario above.
